// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants.
package aes_pkg;

    localparam int BLOCK_WIDTH = 128;
    localparam int BLOCK_BYTES = 16;

    typedef logic [127:0] aes_block_t;
    typedef logic [4:0]   aes_bcnt_t;

    typedef enum logic {
        COLLECT = 1'b0,
        PAD     = 1'b1
    } packer_state_t;

endpackage

// File: rtl/aes_pkcs7_pad.sv
// PKCS#7 padder: bytes at index >= i_bytes are replaced by (16 - i_bytes).
module aes_pkcs7_pad
    import aes_pkg::*;
(
    input  logic [127:0] i_block,
    input  logic [4:0]   i_bytes,
    output logic [127:0] o_block
);

    logic [7:0] w_pad;

    assign w_pad = 8'd16 - {3'b000, i_bytes};

    always_comb begin
        o_block = i_block;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (5'(i) >= i_bytes) begin
                o_block[BLOCK_WIDTH-1-8*i -: 8] = w_pad;
            end
        end
    end

endmodule

// File: rtl/axis_block_packer.sv
// AXI-Stream to 128-bit AES block packer with tkeep/tlast/tuser handling.
// Optional PKCS#7 padding of the final block when AES_PKCS7_PAD_EN is defined.
//
//   state   | meaning
//   COLLECT | accepting beats into the accumulator
//   PAD     | a full final block was emitted; a 16 x 0x10 block is still owed
module axis_block_packer
    import aes_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [TDATA_WIDTH-1:0]   s_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
    input  logic                     s_tlast,
    input  logic                     s_tuser,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [127:0]             m_block,
    output logic [4:0]               m_bytes,
    output logic                     m_last,
    output logic                     m_user
);

    localparam int KB = TDATA_WIDTH / 8;

    if ((BLOCK_WIDTH % TDATA_WIDTH) != 0) begin : g_width_check
        $fatal(1, "axis_block_packer: TDATA_WIDTH must divide 128");
    end

    packer_state_t r_state;
    logic [127:0]  r_acc;
    logic [4:0]    r_cnt;
    logic          r_started;
    logic          r_user;
    logic          r_ready_en;
    logic          r_pad_user;
    logic          r_m_valid;
    logic [127:0]  r_m_block;
    logic [4:0]    r_m_bytes;
    logic          r_m_last;
    logic          r_m_user;

    logic          w_fire;
    logic [127:0]  w_acc_new;
    logic [5:0]    w_kcnt;
    logic [5:0]    w_sum;
    logic          w_full;
    logic [4:0]    w_bytes;
    logic          w_done;
    logic          w_user;

    // Depends only on registered state and m_ready, never on the input beat.
    assign s_tready = r_ready_en & ~(r_m_valid & ~m_ready) & (r_state == COLLECT);
    assign w_fire   = s_tvalid & s_tready;

    // Kept bytes are packed densely after the bytes already held.
    always_comb begin
        w_acc_new = r_acc;
        w_kcnt    = '0;
        for (int j = 0; j < KB; j++) begin
            if (s_tkeep[j]) begin
                if (int'(r_cnt) + int'(w_kcnt) < BLOCK_BYTES) begin
                    w_acc_new[BLOCK_WIDTH-1-8*(int'(r_cnt)+int'(w_kcnt)) -: 8] = s_tdata[8*j +: 8];
                end
                w_kcnt = w_kcnt + 6'd1;
            end
        end
    end

    assign w_sum   = {1'b0, r_cnt} + w_kcnt;
    assign w_full  = (w_sum >= 6'd16);
    assign w_bytes = w_full ? 5'd16 : w_sum[4:0];
    assign w_done  = w_full | s_tlast;
    assign w_user  = r_started ? r_user : s_tuser;

`ifdef AES_PKCS7_PAD_EN
    logic [127:0] w_padded;
    logic         w_need_pad_blk;

    aes_pkcs7_pad u_pad (
        .i_block (w_acc_new),
        .i_bytes (w_bytes),
        .o_block (w_padded)
    );

    // A full (or empty) final block has no room for padding, so a whole pad block follows.
    assign w_need_pad_blk = s_tlast & ((w_bytes == 5'd16) | (w_bytes == 5'd0));
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= COLLECT;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_started  <= 1'b0;
            r_user     <= 1'b0;
            r_ready_en <= 1'b0;
            r_pad_user <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_block  <= '0;
            r_m_bytes  <= '0;
            r_m_last   <= 1'b0;
            r_m_user   <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (r_m_valid & m_ready) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                COLLECT: begin
                    if (w_fire) begin
                        if (w_done) begin
                            r_m_valid <= 1'b1;
                            r_m_user  <= w_user;
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_started <= 1'b0;
`ifdef AES_PKCS7_PAD_EN
                            if (w_need_pad_blk) begin
                                r_m_block  <= w_acc_new;
                                r_m_bytes  <= w_bytes;
                                r_m_last   <= 1'b0;
                                r_pad_user <= w_user;
                                r_state    <= PAD;
                            end else if (s_tlast) begin
                                r_m_block <= w_padded;
                                r_m_bytes <= 5'd16;
                                r_m_last  <= 1'b1;
                            end else begin
                                r_m_block <= w_acc_new;
                                r_m_bytes <= w_bytes;
                                r_m_last  <= 1'b0;
                            end
`else
                            r_m_block <= w_acc_new;
                            r_m_bytes <= w_bytes;
                            r_m_last  <= s_tlast;
`endif
                        end else begin
                            r_acc     <= w_acc_new;
                            r_cnt     <= w_bytes;
                            r_started <= 1'b1;
                            r_user    <= w_user;
                        end
                    end
                end
                PAD: begin
                    if (!r_m_valid | m_ready) begin
                        r_m_valid <= 1'b1;
                        r_m_block <= {16{8'h10}};
                        r_m_bytes <= 5'd16;
                        r_m_last  <= 1'b1;
                        r_m_user  <= r_pad_user;
                        r_state   <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign m_valid = r_m_valid;
    assign m_block = r_m_block;
    assign m_bytes = r_m_bytes;
    assign m_last  = r_m_last;
    assign m_user  = r_m_user;

endmodule

// File: tb/tb_axis_block_packer.sv
// Directed bench for axis_block_packer (32-bit stream); expectations follow AES_PKCS7_PAD_EN.
module tb_axis_block_packer;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_tvalid;
    logic         s_tready;
    logic [31:0]  s_tdata;
    logic [3:0]   s_tkeep;
    logic         s_tlast;
    logic         s_tuser;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_block;
    logic [4:0]   m_bytes;
    logic         m_last;
    logic         m_user;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] q_blk[$];
    logic [4:0]   q_bytes[$];
    logic         q_last[$];
    logic         q_user[$];

    axis_block_packer #(.TDATA_WIDTH(32)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tuser  (s_tuser),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_block  (m_block),
        .m_bytes  (m_bytes),
        .m_last   (m_last),
        .m_user   (m_user)
    );

    always #5 aclk = ~aclk;

    // Inputs change 1 time unit after posedge, so at negedge they hold for the next edge.
    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready) begin
            q_blk.push_back(m_block);
            q_bytes.push_back(m_bytes);
            q_last.push_back(m_last);
            q_user.push_back(m_user);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] seq_word(input int b);
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    function automatic logic [127:0] seq_block(input int base, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[127-8*i -: 8] = 8'(base + i);
        return r;
    endfunction

    function automatic logic [127:0] part_block(input int base, input int n);
        logic [127:0] r;
        r = seq_block(base, n);
`ifdef AES_PKCS7_PAD_EN
        for (int i = n; i < 16; i++) r[127-8*i -: 8] = 8'(16 - n);
`endif
        return r;
    endfunction

    function automatic logic [4:0] part_bytes(input int n);
`ifdef AES_PKCS7_PAD_EN
        return 5'd16;
`else
        return 5'(n);
`endif
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        int t;
        t = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        @(negedge aclk);
        while (!s_tready && t < 200) begin
            t++;
            @(negedge aclk);
        end
        if (!s_tready) chk("beat accept timeout", {127'd0, s_tready}, 128'd1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [127:0] blk, input logic [4:0] bytes,
                             input logic last, input logic user);
        chk({tag, " avail"}, {127'd0, q_blk.size() != 0}, 128'd1);
        if (q_blk.size() != 0) begin
            chk({tag, " block"}, q_blk.pop_front(), blk);
            chk({tag, " bytes"}, {123'd0, q_bytes.pop_front()}, {123'd0, bytes});
            chk({tag, " last"}, {127'd0, q_last.pop_front()}, {127'd0, last});
            chk({tag, " user"}, {127'd0, q_user.pop_front()}, {127'd0, user});
        end
    endtask

    task automatic expect_full_last(input string tag, input int base, input logic user);
`ifdef AES_PKCS7_PAD_EN
        pop_check(tag, seq_block(base, 16), 5'd16, 1'b0, user);
        pop_check({tag, " pad"}, {16{8'h10}}, 5'd16, 1'b1, user);
`else
        pop_check(tag, seq_block(base, 16), 5'd16, 1'b1, user);
`endif
    endtask

    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        #1;
        chk({tag, " valid in reset"}, {127'd0, m_valid}, 128'd0);
        chk({tag, " tready in reset"}, {127'd0, s_tready}, 128'd0);
        idle(2);
        aresetn = 1'b1;
        idle(1);
        chk({tag, " tready after reset"}, {127'd0, s_tready}, 128'd1);
    endtask

    logic [127:0] snap;

    initial begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        m_ready  = 1'b1;
        #1;
        chk("rst tready", {127'd0, s_tready}, 128'd0);
        chk("rst valid", {127'd0, m_valid}, 128'd0);
        chk("rst block", m_block, 128'd0);
        chk("rst bytes", {123'd0, m_bytes}, 128'd0);
        chk("rst last", {127'd0, m_last}, 128'd0);
        chk("rst user", {127'd0, m_user}, 128'd0);
        idle(3);
        aresetn = 1'b1;
        idle(1);
        chk("tready after release", {127'd0, s_tready}, 128'd1);

        // one full block, last on 4th beat
        for (int i = 0; i < 3; i++) send_beat(seq_word(4 * i), 4'hF, 1'b0, 1'b0);
        chk("t1 valid before last", {127'd0, m_valid}, 128'd0);
        send_beat(seq_word(12), 4'hF, 1'b1, 1'b0);
        chk("t1 valid latency", {127'd0, m_valid}, 128'd1);
`ifdef AES_PKCS7_PAD_EN
        chk("t3 tready in pad", {127'd0, s_tready}, 128'd0);
        idle(1);
        chk("t3 tready after pad", {127'd0, s_tready}, 128'd1);
`endif
        idle(4);
        expect_full_last("t1", 0, 1'b0);

        // full block then a 2-byte final beat
        for (int i = 0; i < 4; i++) send_beat(seq_word(8'h40 + 4 * i), 4'hF, 1'b0, 1'b0);
        send_beat(32'h0000_5150, 4'b0011, 1'b1, 1'b0);
        idle(4);
        pop_check("t2 b1", seq_block(8'h40, 16), 5'd16, 1'b0, 1'b0);
        pop_check("t2 b2", part_block(8'h50, 2), part_bytes(2), 1'b1, 1'b0);

        // back-pressure: output held while 8 beats are offered
        m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_beat(seq_word(8'h20 + 4 * i), 4'hF, (i % 4) == 3, 1'b0);
            end
            begin
                idle(6);
                snap = m_block;
                chk("t4 held block", snap, seq_block(8'h20, 16));
                chk("t4 held valid", {127'd0, m_valid}, 128'd1);
                chk("t4 tready low", {127'd0, s_tready}, 128'd0);
                idle(4);
                chk("t4 block stable", m_block, snap);
                chk("t4 tready still low", {127'd0, s_tready}, 128'd0);
                m_ready = 1'b1;
            end
        join
        idle(5);
        expect_full_last("t4 a", 8'h20, 1'b0);
        expect_full_last("t4 b", 8'h30, 1'b0);

        // tuser sampled on first beat only
        send_beat(seq_word(8'h60), 4'hF, 1'b0, 1'b1);
        send_beat(seq_word(8'h64), 4'hF, 1'b0, 1'b0);
        send_beat(seq_word(8'h68), 4'hF, 1'b0, 1'b1);
        send_beat(seq_word(8'h6C), 4'hF, 1'b0, 1'b0);
        send_beat(seq_word(8'h70), 4'hF, 1'b0, 1'b0);
        send_beat(seq_word(8'h74), 4'hF, 1'b0, 1'b1);
        send_beat(seq_word(8'h78), 4'hF, 1'b0, 1'b1);
        send_beat(seq_word(8'h7C), 4'hF, 1'b1, 1'b1);
        idle(4);
        pop_check("t5 b1", seq_block(8'h60, 16), 5'd16, 1'b0, 1'b1);
        expect_full_last("t5 b2", 8'h70, 1'b0);

        // null tlast beat on an empty accumulator
        send_beat(32'hDEAD_BEEF, 4'h0, 1'b1, 1'b0);
        idle(4);
`ifdef AES_PKCS7_PAD_EN
        pop_check("null", 128'd0, 5'd0, 1'b0, 1'b0);
        pop_check("null pad", {16{8'h10}}, 5'd16, 1'b1, 1'b0);
`else
        pop_check("null", 128'd0, 5'd0, 1'b1, 1'b0);
`endif

        // reset with a held output block, then with a partial block
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(seq_word(8'h90 + 4 * i), 4'hF, i == 3, 1'b1);
        chk("t6 held before reset", {127'd0, m_valid}, 128'd1);
        do_reset("t6 held");
        m_ready = 1'b1;
        send_beat(seq_word(8'h80), 4'hF, 1'b0, 1'b1);
        send_beat(seq_word(8'h84), 4'hF, 1'b0, 1'b1);
        do_reset("t6 partial");
        send_beat(seq_word(8'hD0), 4'hF, 1'b1, 1'b0);
        idle(4);
        pop_check("t6 fresh", part_block(8'hD0, 4), part_bytes(4), 1'b1, 1'b0);
        chk("queue drained", {96'd0, 32'(q_blk.size())}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
